// File: rtl/divider_taint_track_bitwise_if.sv
// Request/result bundle for the taint-tracking restoring divider.
// The requester drives the operands and start; the divider returns the
// registered results and the completion pulse. Every data signal has a
// parallel per-bit taint signal with the suffix _t.
interface divider_taint_track_bitwise_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             start_t;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] dividend_t;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] divisor_t;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] quotient_t;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] remainder_t;
    logic             quotientDone;
    logic             quotientDone_t;

    modport master (
        output start, start_t, dividend, dividend_t, divisor, divisor_t,
        input  quotient, quotient_t, remainder, remainder_t,
        input  quotientDone, quotientDone_t
    );

    modport slave (
        input  start, start_t, dividend, dividend_t, divisor, divisor_t,
        output quotient, quotient_t, remainder, remainder_t,
        output quotientDone, quotientDone_t
    );
endinterface

// File: rtl/divider_taint_track_bitwise.sv
// Constant-time restoring divider with bitwise taint tracking.
// One quotient bit per ITER cycle; WIDTH cycles from the start edge to DONE
// for every operand pair, including a zero divisor. Taint rides alongside
// the data without ever steering it.
module divider_taint_track_bitwise #(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    divider_taint_track_bitwise_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] dvd;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvd_t;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dvs_t;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_t;
    logic [CW-1:0]    cnt;
    logic             st_t;

    logic [WIDTH:0]   r_wide;
    logic [WIDTH:0]   r_wide_t;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_sh_t;
    logic [WIDTH-1:0] diff;
    logic             q_bit;
    logic             c_t;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] rem_t_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] q_t_nx;

    // One restoring step and its taint propagation.
    // The partial remainder's top bit is always 0 while iterating, so the
    // compare is done one bit wider without changing its result. The remainder
    // taint is either all zeros or all ones, so OR-reducing the unshifted
    // register plus the incoming bit equals OR-reducing the shifted one.
    always_comb begin
        r_wide   = {rem, dvd[WIDTH-1]};
        r_wide_t = {rem_t, dvd_t[WIDTH-1]};
        r_sh     = r_wide[WIDTH-1:0];
        r_sh_t   = r_wide_t[WIDTH-1:0];
        q_bit    = (r_wide >= {1'b0, dvs});
        diff     = r_sh - dvs;
        c_t      = (|r_wide_t) | (|dvs_t);
        rem_nx   = q_bit ? diff : r_sh;
        rem_t_nx = r_sh_t | {WIDTH{c_t}};
        q_nx     = {dvd[WIDTH-2:0], q_bit};
        q_t_nx   = {dvd_t[WIDTH-2:0], c_t};
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = ITER;
            ITER:    if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand load, iteration registers and result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd             <= '0;
            dvd_t           <= '0;
            dvs             <= '0;
            dvs_t           <= '0;
            rem             <= '0;
            rem_t           <= '0;
            cnt             <= '0;
            st_t            <= 1'b0;
            bus.quotient    <= '0;
            bus.quotient_t  <= '0;
            bus.remainder   <= '0;
            bus.remainder_t <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd   <= bus.dividend;
                        dvd_t <= bus.dividend_t;
                        dvs   <= bus.divisor;
                        dvs_t <= bus.divisor_t;
                        rem   <= '0;
                        rem_t <= '0;
                        cnt   <= '0;
                        st_t  <= bus.start_t;
                    end
                end
                ITER: begin
                    dvd   <= q_nx;
                    dvd_t <= q_t_nx;
                    rem   <= rem_nx;
                    rem_t <= rem_t_nx;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bus.quotient    <= q_nx;
                        bus.remainder   <= rem_nx;
                        bus.quotient_t  <= st_t ? '1 : q_t_nx;
                        bus.remainder_t <= st_t ? '1 : rem_t_nx;
                    end
                end
                DONE: st_t <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.quotientDone   = (state == DONE);
    assign bus.quotientDone_t = (state == DONE) & st_t;
endmodule

// File: tb/tb_divider_taint_track_bitwise.sv
// Directed bench for the taint-tracking divider, WIDTH = 8.
module tb_divider_taint_track_bitwise;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   lat;

    divider_taint_track_bitwise_if #(.WIDTH(W)) ifc ();

    divider_taint_track_bitwise #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and count negedges until quotientDone (bounded).
    task automatic do_div(input logic [W-1:0] dd, input logic [W-1:0] dv,
                          input logic [W-1:0] ddt, input logic [W-1:0] dvt,
                          input logic st, output int l);
        @(negedge clk);
        ifc.start = 1'b1; ifc.start_t = st;
        ifc.dividend = dd; ifc.dividend_t = ddt;
        ifc.divisor = dv; ifc.divisor_t = dvt;
        @(negedge clk);
        ifc.start = 1'b0; ifc.start_t = 1'b0;
        l = 0;
        while (ifc.quotientDone !== 1'b1 && l < 20) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic chk_res(input string tag, input int l,
                           input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic [W-1:0] qt, input logic [W-1:0] rt,
                           input logic dt);
        chk({tag, "_lat"}, l, 8);
        chk({tag, "_q"}, ifc.quotient, q);
        chk({tag, "_r"}, ifc.remainder, r);
        chk({tag, "_qt"}, ifc.quotient_t, qt);
        chk({tag, "_rt"}, ifc.remainder_t, rt);
        chk({tag, "_done_t"}, ifc.quotientDone_t, dt);
        @(negedge clk);
        chk({tag, "_pulse_end"}, ifc.quotientDone, 0);
        chk({tag, "_hold_q"}, ifc.quotient, q);
    endtask

    initial begin
        ifc.start = 1'b0; ifc.start_t = 1'b0;
        ifc.dividend = '0; ifc.dividend_t = '0;
        ifc.divisor = '0; ifc.divisor_t = '0;

        // Reset state
        #2;
        chk("rst_q", ifc.quotient, 0);
        chk("rst_qt", ifc.quotient_t, 0);
        chk("rst_r", ifc.remainder, 0);
        chk("rst_rt", ifc.remainder_t, 0);
        chk("rst_done", ifc.quotientDone, 0);
        chk("rst_done_t", ifc.quotientDone_t, 0);
        @(negedge clk);
        rst = 1'b1;

        // Plain divisions
        do_div(8'd100, 8'd7, 8'h00, 8'h00, 1'b0, lat);
        chk_res("d100_7", lat, 8'd14, 8'd2, 8'h00, 8'h00, 1'b0);
        do_div(8'd255, 8'd1, 8'h00, 8'h00, 1'b0, lat);
        chk_res("d255_1", lat, 8'd255, 8'd0, 8'h00, 8'h00, 1'b0);
        do_div(8'd13, 8'd0, 8'h00, 8'h00, 1'b0, lat);
        chk_res("d13_0", lat, 8'hFF, 8'd13, 8'h00, 8'h00, 1'b0);
        do_div(8'd5, 8'd9, 8'h00, 8'h00, 1'b0, lat);
        chk_res("d5_9", lat, 8'd0, 8'd5, 8'h00, 8'h00, 1'b0);

        // Taint on the dividend LSB only reaches the last step
        do_div(8'd100, 8'd7, 8'h01, 8'h00, 1'b0, lat);
        chk_res("dt01", lat, 8'd14, 8'd2, 8'h01, 8'hFF, 1'b0);
        // Divisor taint taints every step
        do_div(8'd100, 8'd7, 8'h00, 8'h80, 1'b0, lat);
        chk_res("vt80", lat, 8'd14, 8'd2, 8'hFF, 8'hFF, 1'b0);
        // Tainted request
        do_div(8'd100, 8'd7, 8'h00, 8'h00, 1'b1, lat);
        chk_res("st1", lat, 8'd14, 8'd2, 8'hFF, 8'hFF, 1'b1);
        do_div(8'd100, 8'd7, 8'h00, 8'h00, 1'b0, lat);
        chk_res("st_clear", lat, 8'd14, 8'd2, 8'h00, 8'h00, 1'b0);

        // start pulsed mid-division is ignored
        @(negedge clk);
        ifc.start = 1'b1; ifc.dividend = 8'd200; ifc.divisor = 8'd9;
        @(negedge clk);
        ifc.start = 1'b0;
        lat = 0;
        repeat (2) begin @(negedge clk); lat++; end
        ifc.start = 1'b1; ifc.dividend = 8'd50; ifc.divisor = 8'd5;
        @(negedge clk); lat++;
        ifc.start = 1'b0;
        while (ifc.quotientDone !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk_res("ign_start", lat, 8'd22, 8'd2, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("ign_no_restart", ifc.quotientDone, 0);

        // Reset in the middle of a division
        do_div(8'd255, 8'd1, 8'h00, 8'h00, 1'b1, lat);
        chk_res("pre_rst", lat, 8'd255, 8'd0, 8'hFF, 8'hFF, 1'b1);
        @(negedge clk);
        ifc.start = 1'b1; ifc.dividend = 8'd100; ifc.divisor = 8'd7;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_hold_q", ifc.quotient, 8'd255);
        rst = 1'b0;
        #1;
        chk("arst_q", ifc.quotient, 0);
        chk("arst_qt", ifc.quotient_t, 0);
        chk("arst_r", ifc.remainder, 0);
        chk("arst_rt", ifc.remainder_t, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_done", ifc.quotientDone, 0);
        end
        do_div(8'd100, 8'd7, 8'h00, 8'h00, 1'b0, lat);
        chk_res("post_rst", lat, 8'd14, 8'd2, 8'h00, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/divider_taint_track_bitwise.md
DIVIDER_TAINT_TRACK_BITWISE -- requirements
Module: divider_taint_track_bitwise

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the operand, quotient and remainder width in bits (WIDTH >= 2).

Interface
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (rst=0 resets the block).
REQ-004 start, start_t  input  1, 1  request to begin a division / taint of the request.
REQ-005 dividend, dividend_t  input  WIDTH, WIDTH  unsigned dividend / per-bit taint.
REQ-006 divisor, divisor_t  input  WIDTH, WIDTH  unsigned divisor / per-bit taint.
REQ-007 quotient, quotient_t  output  WIDTH, WIDTH  registered quotient / per-bit taint.
REQ-008 remainder, remainder_t  output  WIDTH, WIDTH  registered remainder / per-bit taint.
REQ-009 quotientDone, quotientDone_t  output  1, 1  one-cycle completion pulse / its taint.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, ITER and DONE.
REQ-011 Transitions: IDLE->ITER on a rising edge with start=1; ITER->ITER while the iteration count is below WIDTH-1; ITER->DONE on the edge that completes iteration WIDTH-1; DONE->IDLE unconditionally.
REQ-012 In IDLE with start=1, that edge SHALL load the internal dividend shift register, divisor register and taints, clear the partial remainder and its taint, and clear the counter.
REQ-013 start SHALL be ignored in ITER and DONE; no queuing and no restart.
REQ-014 Each ITER edge SHALL perform one restoring step.
  - R' = {R[WIDTH-2:0], dividend MSB}; the dividend register shifts left.
  - Compute diff = R' - divisor.
  - If R' >= divisor: R = diff and quotient bit = 1.
  - Otherwise: R = R' and quotient bit = 0.
  - The quotient bit shifts in at the LSB.
REQ-015 Latency SHALL be fixed at WIDTH edges from the start-sampling edge to DONE, independent of operand values, including divisor = 0 (constant time).
REQ-016 Divide by zero SHALL need no special casing: quotient = all ones, remainder = dividend.
REQ-017 quotient and remainder SHALL update only on the ITER->DONE edge, and SHALL hold until the next completion.
REQ-018 quotientDone SHALL be 1 only while in DONE (exactly one cycle).
REQ-019 Taint rules, applied per iteration:
  - Compare taint c_t = OR-reduce of R'_t and divisor_t.
  - Difference taint = {WIDTH{c_t}}.
  - New R_t = R'_t | {WIDTH{c_t}}.
  - The quotient taint bit shifted in = c_t.
  - R'_t SHALL shift in the dividend_t MSB in step with the data.
REQ-020 State taint st_t:
  - Loaded with start_t on the IDLE->ITER edge.
  - Held through ITER and DONE.
  - Cleared on DONE->IDLE.
REQ-021 While st_t=1, the ITER->DONE edge SHALL force quotient_t and remainder_t to all ones, and quotientDone_t SHALL equal st_t during DONE; otherwise quotientDone_t = 0.
REQ-022 Taint tracking SHALL never alter the data path values.

Reset
REQ-023 rst=0 SHALL immediately force the following, regardless of clk and even mid-division; the aborted operation produces no quotientDone.
  - State = IDLE.
  - quotient, quotient_t, remainder, remainder_t = 0.
  - quotientDone, quotientDone_t = 0.
  - All internal registers, taints, st_t and the counter = 0.
REQ-024 After rst returns to 1, the first rising edge with start=1 SHALL begin a normal division.

Verification (WIDTH=8)
REQ-025 start with dividend=100, divisor=7, all taints 0 -> quotientDone pulses 8 edges after the start edge; quotient=14, remainder=2; both taints 0x00; quotientDone_t=0.
REQ-026 dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=13, divisor=0 -> quotient=0xFF, remainder=13. Both take identical latency.
REQ-027 dividend=100, divisor=7, dividend_t=0x01, other taints 0 -> quotient=14, remainder=2, quotient_t=0x01, remainder_t=0xFF.
REQ-028 dividend=100, divisor=7, start_t=1, data taints 0 -> quotientDone_t=1, quotient_t=0xFF, remainder_t=0xFF. The next untainted division returns all taints to 0.
REQ-029 Pulse start again during ITER -> ignored, and the result is unchanged. Assert rst=0 at iteration 4 -> all outputs 0 at once and no quotientDone; a fresh start then yields the correct result.
